// File: rtl/rst_scoreboard.sv
// Register status table: per-register busy bit and producer tag, set at dispatch,
// cleared by tag-matched writebacks, with optional same-cycle writeback bypass.

module rst_scoreboard_entry #(
  parameter int IDX       = 0,
  parameter int IDX_W     = 5,
  parameter int TAG_W     = 2,
  parameter int NUM_WB    = 2,
  parameter bit WB_BYPASS = 1'b1,
  parameter bit HARD_ZERO = 1'b0
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    set,
  input  logic [TAG_W-1:0]        set_tag,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_rd,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  output logic                    busy,
  output logic                    busy_nxt,
  output logic                    beff,
  output logic [TAG_W-1:0]        tag
);

  logic             busy_q, busy_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             clr_hit;

  always_comb begin
    clr_hit = 1'b0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_valid[p] && (wb_rd[p*IDX_W +: IDX_W] == IDX_W'(IDX)) &&
          (wb_tag[p*TAG_W +: TAG_W] == tag_q))
        clr_hit = 1'b1;
    end
    // A stale or duplicate writeback never touches an idle entry.
    clr_hit = clr_hit && busy_q;
    beff    = busy_q && !(WB_BYPASS && clr_hit);

    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush) begin
      busy_d = 1'b0;
    end else if (set) begin
      busy_d = 1'b1;
      tag_d  = set_tag;
    end else if (clr_hit) begin
      busy_d = 1'b0;
    end
    if (HARD_ZERO) busy_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      busy_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  assign busy     = busy_q;
  assign busy_nxt = busy_d;
  assign tag      = tag_q;

endmodule

module rst_scoreboard #(
  parameter int NUM_REGS       = 32,
  parameter int TAG_W          = 2,
  parameter int NUM_WB         = 2,
  parameter int NUM_SRC        = 2,
  parameter bit ZERO_HARDWIRED = 1'b1,
  parameter bit WB_BYPASS      = 1'b1,
  parameter int IDX_W          = $clog2(NUM_REGS)
) (
  input  logic                           CLK,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           di_valid,
  input  logic                           di_rd_en,
  input  logic [IDX_W-1:0]               di_rd,
  input  logic [TAG_W-1:0]               di_tag,
  output logic                           di_ready,
  input  logic [NUM_SRC*IDX_W-1:0]       src_idx,
  output logic [NUM_SRC-1:0]             src_busy,
  output logic [NUM_SRC*TAG_W-1:0]       src_tag,
  input  logic [NUM_WB-1:0]              wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]        wb_rd,
  input  logic [NUM_WB*TAG_W-1:0]        wb_tag,
  output logic [NUM_REGS-1:0]            busy_vec,
  output logic [$clog2(NUM_REGS+1)-1:0]  busy_count
);

  localparam int                CNT_W   = $clog2(NUM_REGS+1);
  localparam logic [IDX_W:0]    REG_LIM = (IDX_W+1)'(NUM_REGS);

  logic [NUM_REGS-1:0]             busy_nxt_vec;
  logic [NUM_REGS-1:0]             beff_vec;
  logic [NUM_REGS-1:0][TAG_W-1:0]  tag_vec;
  logic [CNT_W-1:0]                busy_count_q, busy_count_d;
  logic                            rd_in_rng;
  logic                            rd_beff;
  logic                            di_set;

  // Out-of-range indices (non power-of-two files) read as idle and are never set.
  assign rd_in_rng = {1'b0, di_rd} < REG_LIM;
  assign rd_beff   = rd_in_rng && beff_vec[di_rd];
  assign di_ready  = !(di_rd_en && rd_beff);
  assign di_set    = di_valid && di_ready && di_rd_en && rd_in_rng &&
                     !(ZERO_HARDWIRED && (di_rd == '0));

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_ent
    rst_scoreboard_entry #(
      .IDX       (r),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W),
      .NUM_WB    (NUM_WB),
      .WB_BYPASS (WB_BYPASS),
      .HARD_ZERO (ZERO_HARDWIRED && (r == 0))
    ) u_ent (
      .CLK      (CLK),
      .rst      (rst),
      .flush    (flush),
      .set      (di_set && (di_rd == IDX_W'(r))),
      .set_tag  (di_tag),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_tag   (wb_tag),
      .busy     (busy_vec[r]),
      .busy_nxt (busy_nxt_vec[r]),
      .beff     (beff_vec[r]),
      .tag      (tag_vec[r])
    );
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [IDX_W-1:0] sidx;
    logic             in_rng;
    assign sidx   = src_idx[i*IDX_W +: IDX_W];
    assign in_rng = {1'b0, sidx} < REG_LIM;
    assign src_busy[i] = in_rng && beff_vec[sidx] && !(ZERO_HARDWIRED && (sidx == '0));
    assign src_tag[i*TAG_W +: TAG_W] = in_rng ? tag_vec[sidx] : '0;
  end

  // Count follows the next-state vector so it lands on the same edge as busy_vec.
  always_comb begin
    busy_count_d = '0;
    for (int r = 0; r < NUM_REGS; r++)
      busy_count_d = busy_count_d + CNT_W'(busy_nxt_vec[r]);
  end

  always_ff @(posedge CLK) begin
    if (rst) busy_count_q <= '0;
    else     busy_count_q <= busy_count_d;
  end

  assign busy_count = busy_count_q;

endmodule

// File: doc/rst_scoreboard.md
Name: rst_scoreboard

Overview:
- Parametrised register status table (RST) tracking in-flight destination registers between dispatch and writeback.
- Generalises the fixed scalar and matrix RSTs (one busy bit and 2-bit tag per register) to configurable register count, tag width, writeback port count and source-lookup port count.
- Adds tag-checked clears, writeback bypass, WAW stall and flush.
- One instance serves the scalar file (32 regs); a second serves the matrix file (16 regs).

Parameters:
NUM_REGS, 32, number of tracked registers (>=2)
TAG_W, 2, producing-FU tag width
NUM_WB, 2, writeback clear ports
NUM_SRC, 2, source lookup ports
ZERO_HARDWIRED, 1, 1 = register 0 never busy (scalar x0); 0 for matrix file
WB_BYPASS, 1, 1 = same-cycle writeback clear visible on lookups and di_ready
IDX_W, $clog2(NUM_REGS), derived register index width

Ports:
CLK  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  clear all entries
di_valid  in  1  dispatch request
di_rd_en  in  1  dispatch instruction writes a register
di_rd  in  IDX_W  destination register
di_tag  in  TAG_W  FU tag of producer
di_ready  out  1  dispatch may proceed (no WAW hazard)
src_idx  in  NUM_SRC*IDX_W  source register indices
src_busy  out  NUM_SRC  source pending
src_tag  out  NUM_SRC*TAG_W  producing tag of source
wb_valid  in  NUM_WB  writeback clear request
wb_rd  in  NUM_WB*IDX_W  written register
wb_tag  in  NUM_WB*TAG_W  tag of finishing FU
busy_vec  out  NUM_REGS  registered busy bits
busy_count  out  $clog2(NUM_REGS+1)  registered popcount of busy_vec

Behaviour:
- State: busy[NUM_REGS], tag[NUM_REGS][TAG_W].
- Reset (rst=1 at CLK edge): all busy=0, all tag=0, busy_count=0. Reset outranks flush, dispatch and wb.
- Reset mid-operation discards all pending entries; writebacks arriving after reset are ignored because busy=0.
- Clear match for port p, register r: wb_valid[p] && wb_rd[p]==r && busy[r] && wb_tag[p]==tag[r].
  - Tag mismatch: no effect (stale or duplicate writeback).
  - Several ports matching the same register clear it once.
- Effective busy: beff[r] = busy[r] && !(WB_BYPASS && any clear match on r). With WB_BYPASS=0, beff = busy.
- src_busy[i] = beff[src_idx[i]] and src_tag[i] = tag[src_idx[i]]; both combinational.
- Index 0 with ZERO_HARDWIRED=1: src_busy=0.
- Index >= NUM_REGS: src_busy=0, src_tag=0.
- di_ready = !(di_rd_en && beff[di_rd]). With ZERO_HARDWIRED, di_rd=0 always gives ready. di_ready is independent of di_valid.
- Set: di_valid && di_ready && di_rd_en && !(ZERO_HARDWIRED && di_rd==0) -> next busy[di_rd]=1, tag[di_rd]=di_tag.
- Next-state priority per register: rst > flush (busy=0, tag unchanged) > set > clear > hold.
  - Set and clear on the same register in one cycle: set wins; new tag kept, busy=1.
- di_valid with di_rd_en=0: no state change.
- Dispatch blocked (di_ready=0): no state change; upstream holds the request.
- busy_count equals popcount of the registered busy_vec and updates the same edge as busy_vec; max value NUM_REGS, no wrap.
- All outputs except busy_vec and busy_count are combinational. A state update is visible one cycle after the edge.

Test Plan:
- Reset then dispatch rd=5 tag=2 -> next cycle busy_vec[5]=1, busy_count=1; lookup src_idx=5 gives src_busy=1, src_tag=2.
- With reg5 busy tag=2: wb rd=5 tag=1 -> no change. Then wb rd=5 tag=2 -> src_busy=0 same cycle (bypass); busy_vec[5]=0 and busy_count=0 next cycle.
- Reg5 busy tag=2: dispatch rd=5 tag=3 with wb rd=5 tag=2 in the same cycle -> di_ready=1; next cycle busy[5]=1, tag[5]=3. Repeat with WB_BYPASS=0 -> di_ready=0, reg5 cleared, no set.
- Dispatch rd=0 with ZERO_HARDWIRED=1 -> di_ready=1, busy_vec stays 0. Dispatch to all regs 1..31 -> busy_count=31; assert flush with a concurrent dispatch to rd=7 -> next cycle busy_vec=0, busy_count=0.
- Both wb ports target reg9 with tag=1 and tag[9]=1 -> single clear, busy_count decrements by exactly 1.
- NUM_REGS=16, TAG_W=3, NUM_WB=3 (matrix configuration): fill regs 0..15 -> busy_count=16; assert rst mid-stream -> all zero next cycle; a later wb rd=3 tag=4 -> no effect.
